// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: live config struct, chip address rule, decoded
// transaction record and decoder defaults.
package hyperbus_pkg;

    localparam int unsigned NumPhys                  = 2;
    localparam int unsigned DecMaxOutstandingDefault = 4;

    typedef struct packed {
        logic [3:0]  t_latency_access;
        logic        en_latency_additional;
        logic [15:0] t_burst_max;
        logic [3:0]  t_read_write_recovery;
        logic [4:0]  address_mask_msb;
        logic        address_space;
    } hyper_cfg_t;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } hyper_rule_t;

    typedef struct packed {
        logic [1:0]  cs;
        logic [31:0] addr;
        logic        write;
        logic [15:0] burst;
        logic        error;
    } hyper_trx_dec_t;

endpackage

// File: rtl/hyperbus_chip_match.sv
// Combinational chip decode: compares a (pre-shifted) key against every chip
// rule and returns a one-hot select, lowest matching index winning.
module hyperbus_chip_match
    import hyperbus_pkg::*;
#(
    parameter int unsigned NumChips  = 2,
    parameter int unsigned AddrWidth = 32,
    parameter type         rule_t    = hyper_rule_t
) (
    input  logic [AddrWidth-1:0] i_key,
    input  rule_t                i_rules [NumChips],
    output logic [NumChips-1:0]  o_cs,
    output logic                 o_error
);

    logic w_found;
    logic w_unused_idx;

    // Priority range match: first rule with start <= key < end selects.
    always_comb begin
        o_cs         = '0;
        w_found      = 1'b0;
        w_unused_idx = 1'b0;
        for (int unsigned i = 0; i < NumChips; i++) begin
            w_unused_idx = w_unused_idx ^ (^i_rules[i].idx);
            if (!w_found &&
                (i_key >= AddrWidth'(i_rules[i].start_addr)) &&
                (i_key <  AddrWidth'(i_rules[i].end_addr))) begin
                o_cs[i] = 1'b1;
                w_found = 1'b1;
            end
        end
        o_error = ~w_found;
    end

endmodule

// File: rtl/hyperbus_trans_decoder.sv
// HyperBus transaction decoder: registers each request with its decoded chip
// select and chip-local address, and tracks outstanding transactions.
// Optional macro HYPERBUS_DECODE_ERR_CNT_EN adds a saturating decode-error
// counter on err_count_o.
module hyperbus_trans_decoder
    import hyperbus_pkg::*;
#(
    parameter int unsigned NumChips       = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned BurstWidth     = 16,
    parameter int unsigned MaxOutstanding = DecMaxOutstandingDefault,
    parameter type         rule_t         = hyper_rule_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  hyper_cfg_t            cfg_i,
    input  rule_t                 chip_rules_i [NumChips],
    input  logic                  trx_valid_i,
    output logic                  trx_ready_o,
    input  logic [AddrWidth-1:0]  trx_addr_i,
    input  logic                  trx_write_i,
    input  logic [BurstWidth-1:0] trx_burst_i,
    output logic                  trx_valid_o,
    input  logic                  trx_ready_i,
    output logic [NumChips-1:0]   trx_cs_o,
    output logic [AddrWidth-1:0]  trx_addr_o,
    output logic                  trx_write_o,
    output logic [BurstWidth-1:0] trx_burst_o,
    output logic                  trx_error_o,
    input  logic                  trx_done_i,
    output logic                  trans_active_o
`ifdef HYPERBUS_DECODE_ERR_CNT_EN
    ,
    output logic [15:0]           err_count_o
`endif
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    // Same layout as hyper_trx_dec_t, sized by this instance's parameters.
    typedef struct packed {
        logic [NumChips-1:0]   cs;
        logic [AddrWidth-1:0]  addr;
        logic                  write;
        logic [BurstWidth-1:0] burst;
        logic                  error;
    } trx_dec_t;

    logic [AddrWidth-1:0] w_key;
    logic [AddrWidth-1:0] w_mask;
    logic [NumChips-1:0]  w_cs;
    logic                 w_error;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_unused_cfg;
    trx_dec_t             w_dec;

    trx_dec_t             r_dec;
    logic                 r_valid;
    logic [CntWidth-1:0]  r_count;

    assign w_key        = trx_addr_i >> (NumPhys - 1);
    assign w_unused_cfg = ^cfg_i;

    hyperbus_chip_match #(
        .NumChips  (NumChips),
        .AddrWidth (AddrWidth),
        .rule_t    (rule_t)
    ) u_chip_match (
        .i_key   (w_key),
        .i_rules (chip_rules_i),
        .o_cs    (w_cs),
        .o_error (w_error)
    );

    // Chip-local mask: bits [address_mask_msb:0] set; saturates to all ones.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < AddrWidth; i++) begin
            w_mask[i] = (i <= int'(cfg_i.address_mask_msb));
        end
    end

    // Assemble the decoded record from the live inputs.
    always_comb begin
        w_dec       = '0;
        w_dec.cs    = w_cs;
        w_dec.addr  = trx_addr_i & w_mask;
        w_dec.write = trx_write_i;
        w_dec.burst = trx_burst_i;
        w_dec.error = w_error;
    end

    // Ready uses only registered state plus the downstream ready, so a done
    // pulse at the outstanding limit reopens the input one cycle later.
    assign w_ready  = (~r_valid | trx_ready_i) & (r_count < CntWidth'(MaxOutstanding));
    assign w_accept = trx_valid_i & w_ready;
    assign w_done   = trx_done_i & (r_count != '0);

    // Single output register stage; data only loads on input handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_dec   <= w_dec;
        end else if (trx_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // Outstanding counter: up on acceptance, down on done, hold on both.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else begin
            case ({w_accept, w_done})
                2'b10:   r_count <= r_count + CntWidth'(1);
                2'b01:   r_count <= r_count - CntWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) trx_done_i |-> (r_count != '0));

`ifdef HYPERBUS_DECODE_ERR_CNT_EN
    logic [15:0] r_err_count;

    // Saturating count of accepted requests that matched no chip rule.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_count <= '0;
        end else if (w_accept && w_error && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count_o = r_err_count;
`endif

    assign trx_ready_o    = w_ready;
    assign trx_valid_o    = r_valid;
    assign trx_cs_o       = r_dec.cs;
    assign trx_addr_o     = r_dec.addr;
    assign trx_write_o    = r_dec.write;
    assign trx_burst_o    = r_dec.burst;
    assign trx_error_o    = r_dec.error;
    assign trans_active_o = (r_count != '0);

endmodule

// File: tb/tb_hyperbus_trans_decoder.sv
// Scoreboard bench for hyperbus_trans_decoder; honours HYPERBUS_DECODE_ERR_CNT_EN.
module tb_hyperbus_trans_decoder;
    import hyperbus_pkg::*;

    logic        clk;
    logic        rst_ni;
    hyper_cfg_t  cfg;
    hyper_rule_t rules [2];
    logic        trx_valid_i;
    logic        trx_ready_o;
    logic [31:0] trx_addr_i;
    logic        trx_write_i;
    logic [15:0] trx_burst_i;
    logic        trx_valid_o;
    logic        trx_ready_i;
    logic [1:0]  trx_cs_o;
    logic [31:0] trx_addr_o;
    logic        trx_write_o;
    logic [15:0] trx_burst_o;
    logic        trx_error_o;
    logic        trx_done_i;
    logic        trans_active_o;
`ifdef HYPERBUS_DECODE_ERR_CNT_EN
    logic [15:0] err_count_o;
`endif

    typedef struct {
        logic [1:0]  cs;
        logic [31:0] addr;
        logic        wr;
        logic [15:0] burst;
        logic        err;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;

    hyperbus_trans_decoder #(
        .NumChips       (2),
        .AddrWidth      (32),
        .BurstWidth     (16),
        .MaxOutstanding (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .cfg_i          (cfg),
        .chip_rules_i   (rules),
        .trx_valid_i    (trx_valid_i),
        .trx_ready_o    (trx_ready_o),
        .trx_addr_i     (trx_addr_i),
        .trx_write_i    (trx_write_i),
        .trx_burst_i    (trx_burst_i),
        .trx_valid_o    (trx_valid_o),
        .trx_ready_i    (trx_ready_i),
        .trx_cs_o       (trx_cs_o),
        .trx_addr_o     (trx_addr_o),
        .trx_write_o    (trx_write_o),
        .trx_burst_o    (trx_burst_o),
        .trx_error_o    (trx_error_o),
        .trx_done_i     (trx_done_i),
        .trans_active_o (trans_active_o)
`ifdef HYPERBUS_DECODE_ERR_CNT_EN
        ,
        .err_count_o    (err_count_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_err(input string nm, input logic [15:0] exp);
`ifdef HYPERBUS_DECODE_ERR_CNT_EN
        chk(nm, 64'(err_count_o), 64'(exp));
`else
        if (exp == 16'hFFFF) $display("note: %s", nm);
`endif
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offer one request; push its expected output when it is accepted.
    task automatic send(input logic [31:0] a, input logic w, input logic [15:0] b,
                        input logic [1:0] ecs, input logic [31:0] eaddr,
                        input logic eerr, input logic wd);
        exp_t e;
        logic ok;
        logic acc;
        trx_valid_i = 1'b1;
        trx_addr_i  = a;
        trx_write_i = w;
        trx_burst_i = b;
        trx_done_i  = wd;
        ok          = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            acc = trx_ready_o;
            if (acc) begin
                e.cs = ecs; e.addr = eaddr; e.wr = w; e.burst = b; e.err = eerr;
                exp_q.push_back(e);
                ok = 1'b1;
            end
            sync();
            trx_done_i = 1'b0;
            if (acc) break;
        end
        trx_valid_i = 1'b0;
        chk($sformatf("accept_%h", a), 64'(ok), 64'd1);
    endtask

    task automatic pulse_done();
        trx_done_i = 1'b1;
        sync();
        trx_done_i = 1'b0;
    endtask

    // Monitor: every output handshake is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_ni && trx_valid_o && trx_ready_i) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                chk($sformatf("unexpected_out%0d", n_out),
                    {12'd0, trx_cs_o, trx_addr_o, trx_write_o, trx_burst_o, trx_error_o}, '1);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("out%0d", n_out),
                    {12'd0, trx_cs_o, trx_addr_o, trx_write_o, trx_burst_o, trx_error_o},
                    {12'd0, e.cs, e.addr, e.wr, e.burst, e.err});
            end
            n_out++;
        end
    end

    initial begin
        rst_ni      = 1'b0;
        trx_valid_i = 1'b0;
        trx_addr_i  = '0;
        trx_write_i = 1'b0;
        trx_burst_i = '0;
        trx_ready_i = 1'b1;
        trx_done_i  = 1'b0;
        cfg         = '0;
        cfg.address_mask_msb = 5'd15;
        rules[0] = '{idx: 32'd0, start_addr: 32'h4000_0000, end_addr: 32'h4000_8000};
        rules[1] = '{idx: 32'd1, start_addr: 32'h4000_8000, end_addr: 32'h4001_0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(trx_valid_o), 64'd0);
        chk("rst_outs", {12'd0, trx_cs_o, trx_addr_o, trx_write_o, trx_burst_o, trx_error_o}, 64'd0);
        chk("rst_active", 64'(trans_active_o), 64'd0);
        chk_err("rst_err_count", 16'd0);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(trx_ready_o), 64'd1);
        chk("idle_valid", 64'(trx_valid_o), 64'd0);
        sync();

        // Decode, back to back, until the outstanding limit is reached.
        send(32'h8001_0004, 1'b1, 16'd8,  2'b10, 32'h0000_0004, 1'b0, 1'b0);
        send(32'h8000_1234, 1'b0, 16'd4,  2'b01, 32'h0000_1234, 1'b0, 1'b0);
        send(32'h9000_0000, 1'b1, 16'd1,  2'b00, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h8000_FFFE, 1'b0, 16'd16, 2'b01, 32'h0000_FFFE, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_ready", 64'(trx_ready_o), 64'd0);
        chk("full_active", 64'(trans_active_o), 64'd1);
        sync();
        trx_done_i = 1'b1;
        @(negedge clk);
        chk("done_no_reopen", 64'(trx_ready_o), 64'd0);
        sync();
        trx_done_i = 1'b0;
        @(negedge clk);
        chk("reopen_ready", 64'(trx_ready_o), 64'd1);
        sync();

        send(32'h8001_0000, 1'b1, 16'd2, 2'b10, 32'h0000_0000, 1'b0, 1'b0);
        pulse_done();
        pulse_done();

        // Downstream stall: held output, config changes must not leak in.
        trx_ready_i = 1'b0;
        send(32'h8000_ABCD, 1'b0, 16'd3, 2'b01, 32'h0000_ABCD, 1'b0, 1'b0);
        trx_valid_i = 1'b1;
        trx_addr_i  = 32'h7FFF_FFFE;
        trx_write_i = 1'b1;
        trx_burst_i = 16'd5;
        cfg.address_mask_msb = 5'd3;
        rules[0].start_addr  = 32'h0000_0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold_valid%0d", k), 64'(trx_valid_o), 64'd1);
            chk($sformatf("hold_cs%0d", k),    64'(trx_cs_o),    64'd1);
            chk($sformatf("hold_addr%0d", k),  64'(trx_addr_o),  64'h0000_ABCD);
            chk($sformatf("hold_err%0d", k),   64'(trx_error_o), 64'd0);
            chk($sformatf("hold_ready%0d", k), 64'(trx_ready_o), 64'd0);
        end
        sync();
        cfg.address_mask_msb = 5'd15;
        rules[0].start_addr  = 32'h4000_0000;
        trx_ready_i = 1'b1;
        send(32'h7FFF_FFFE, 1'b1, 16'd5, 2'b00, 32'h0000_FFFE, 1'b1, 1'b0);
        pulse_done();
        pulse_done();

        // Accept and done in the same cycle at count 2, then drain.
        send(32'h8001_FFFE, 1'b0, 16'd7, 2'b10, 32'h0000_FFFE, 1'b0, 1'b1);
        pulse_done();
        @(negedge clk);
        chk("active_after_first_done", 64'(trans_active_o), 64'd1);
        sync();
        trx_done_i = 1'b1;
        @(negedge clk);
        chk("active_during_last_done", 64'(trans_active_o), 64'd1);
        sync();
        trx_done_i = 1'b0;
        @(negedge clk);
        chk("active_fall", 64'(trans_active_o), 64'd0);
        sync();

        // Build count 3 with a stalled output, then reset mid-flight.
        send(32'h8000_0002, 1'b1, 16'hFFFF, 2'b01, 32'h0000_0002, 1'b0, 1'b0);
        send(32'h8002_0000, 1'b0, 16'd9,    2'b00, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h1234_5678, 1'b1, 16'd6,    2'b00, 32'h0000_5678, 1'b1, 1'b0);
        trx_ready_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(trx_valid_o), 64'd1);
        chk("pre_rst_active", 64'(trans_active_o), 64'd1);
        chk_err("pre_rst_err_count", 16'd4);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(trx_valid_o), 64'd0);
        chk("mid_rst_active", 64'(trans_active_o), 64'd0);
        chk("mid_rst_cs", 64'(trx_cs_o), 64'd0);
        chk_err("mid_rst_err_count", 16'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        trx_ready_i = 1'b1;
        sync();
        send(32'h8000_0010, 1'b0, 16'd2, 2'b01, 32'h0000_0010, 1'b0, 1'b0);

        // Overlapping rules: lowest index wins.
        rules[1].start_addr = 32'h4000_0000;
        send(32'h8000_0100, 1'b1, 16'd1, 2'b01, 32'h0000_0100, 1'b0, 1'b0);
        rules[1].start_addr = 32'h4000_8000;
        pulse_done();
        pulse_done();

        // Mask boundaries.
        cfg.address_mask_msb = 5'd31;
        send(32'h8001_0004, 1'b0, 16'd1, 2'b10, 32'h8001_0004, 1'b0, 1'b0);
        cfg.address_mask_msb = 5'd30;
        send(32'h8001_0004, 1'b1, 16'd2, 2'b10, 32'h0001_0004, 1'b0, 1'b0);
        cfg.address_mask_msb = 5'd0;
        send(32'h8001_0005, 1'b0, 16'd3, 2'b10, 32'h0000_0001, 1'b0, 1'b0);
        pulse_done();
        pulse_done();
        pulse_done();

        repeat (2) @(negedge clk);
        chk("end_active", 64'(trans_active_o), 64'd0);
        chk("end_drained", 64'(exp_q.size()), 64'd0);
        chk_err("end_err_count", 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
